// File: rtl/int_arbiter_if.sv
// CPU-side bus of the interrupt arbiter: configuration writes, ack/eoi handshakes,
// and the request/vector/status outputs.
interface int_arbiter_if #(
  parameter int NSRC = 8
);
  logic            cfg_we;
  logic [1:0]      cfg_addr;
  logic [NSRC-1:0] cfg_wdata;
  logic            irq_ack;
  logic            fiq_ack;
  logic            irq_eoi;
  logic            fiq_eoi;
  logic            EX_irq;
  logic            EX_fiq;
  logic [31:0]     INT_Vector;
  logic [3:0]      irq_id;
  logic [3:0]      fiq_id;
  logic [NSRC-1:0] pending;
  logic [1:0]      in_service;

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, irq_ack, fiq_ack, irq_eoi, fiq_eoi,
    output EX_irq, EX_fiq, INT_Vector, irq_id, fiq_id, pending, in_service
  );

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, irq_ack, fiq_ack, irq_eoi, fiq_eoi,
    input  EX_irq, EX_fiq, INT_Vector, irq_id, fiq_id, pending, in_service
  );
endinterface

// File: rtl/int_arbiter.sv
// Interrupt arbiter: synchronised edge-triggered sources, pending/mask/class registers,
// and one IDLE/ASSERT/SERVICE channel per class (IRQ, FIQ) with fixed lowest-index priority.
module int_arbiter #(
  parameter int          NSRC     = 8,
  parameter logic [31:0] IRQ_BASE = 32'h0000_0018,
  parameter logic [31:0] FIQ_BASE = 32'h0000_001C
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic [NSRC-1:0] src_in,
  int_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, SERVICE = 2'd2} ch_state_t;

  logic [NSRC-1:0] s1, s2, s3;
  logic [NSRC-1:0] pend_q, pend_n;
  logic [NSRC-1:0] mask_q, fsel_q;
  logic [NSRC-1:0] rise, irq_cand, fiq_cand;
  logic [15:0]     live16, clr16;

  ch_state_t irq_st, irq_st_n, fiq_st, fiq_st_n;
  logic [3:0]  irq_id_q, irq_id_n, fiq_id_q, fiq_id_n;
  logic        irq_clr, fiq_clr;
  logic        ex_irq_q, ex_irq_n, ex_fiq_q, ex_fiq_n;
  logic [31:0] vec_q, vec_n;
  logic [1:0]  insvc_q, insvc_n;

  function automatic logic [3:0] lowest(input logic [NSRC-1:0] v);
    lowest = '0;
    for (int unsigned i = NSRC; i > 0; i--)
      if (v[i-1]) lowest = 4'(i - 1);
  endfunction

  assign rise     = s2 & ~s3;
  assign irq_cand = pend_q & mask_q & ~fsel_q;
  assign fiq_cand = pend_q & mask_q & fsel_q;
  // Widened to 16 so a 4-bit id indexes it directly for any NSRC.
  assign live16   = 16'(pend_q & mask_q);

  always_comb begin
    irq_st_n = irq_st;
    irq_id_n = irq_id_q;
    irq_clr  = 1'b0;
    case (irq_st)
      IDLE: if (|irq_cand && fiq_st != SERVICE) begin
        irq_st_n = ASSERT;
        irq_id_n = lowest(irq_cand);
      end
      ASSERT: begin
        if (!live16[irq_id_q]) irq_st_n = IDLE;
        else if (bus.irq_ack) begin
          irq_st_n = SERVICE;
          irq_clr  = 1'b1;
        end
      end
      SERVICE: if (bus.irq_eoi) irq_st_n = IDLE;
      default: irq_st_n = IDLE;
    endcase
  end

  always_comb begin
    fiq_st_n = fiq_st;
    fiq_id_n = fiq_id_q;
    fiq_clr  = 1'b0;
    case (fiq_st)
      IDLE: if (|fiq_cand) begin
        fiq_st_n = ASSERT;
        fiq_id_n = lowest(fiq_cand);
      end
      ASSERT: begin
        if (!live16[fiq_id_q]) fiq_st_n = IDLE;
        else if (bus.fiq_ack) begin
          fiq_st_n = SERVICE;
          fiq_clr  = 1'b1;
        end
      end
      SERVICE: if (bus.fiq_eoi) fiq_st_n = IDLE;
      default: fiq_st_n = IDLE;
    endcase
  end

  // Hardware rises are applied last so they win over any clear in the same cycle.
  always_comb begin
    clr16  = (16'(irq_clr) << irq_id_q) | (16'(fiq_clr) << fiq_id_q);
    pend_n = pend_q;
    if (bus.cfg_we && bus.cfg_addr == 2'd2) pend_n = pend_n | bus.cfg_wdata;
    if (bus.cfg_we && bus.cfg_addr == 2'd3) pend_n = pend_n & ~bus.cfg_wdata;
    pend_n = (pend_n & ~clr16[NSRC-1:0]) | rise;
  end

  always_comb begin
    ex_irq_n = (irq_st_n == ASSERT);
    ex_fiq_n = (fiq_st_n == ASSERT);
    insvc_n  = {fiq_st_n == SERVICE, irq_st_n == SERVICE};
    vec_n    = '0;
    if (ex_fiq_n)      vec_n = FIQ_BASE + {26'b0, fiq_id_n, 2'b00};
    else if (ex_irq_n) vec_n = IRQ_BASE + {26'b0, irq_id_n, 2'b00};
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      fsel_q   <= '0;
      irq_st   <= IDLE;
      fiq_st   <= IDLE;
      irq_id_q <= '0;
      fiq_id_q <= '0;
      ex_irq_q <= 1'b0;
      ex_fiq_q <= 1'b0;
      vec_q    <= '0;
      insvc_q  <= '0;
    end else begin
      s1       <= src_in;
      s2       <= s1;
      s3       <= s2;
      pend_q   <= pend_n;
      if (bus.cfg_we && bus.cfg_addr == 2'd0) mask_q <= bus.cfg_wdata;
      if (bus.cfg_we && bus.cfg_addr == 2'd1) fsel_q <= bus.cfg_wdata;
      irq_st   <= irq_st_n;
      fiq_st   <= fiq_st_n;
      irq_id_q <= irq_id_n;
      fiq_id_q <= fiq_id_n;
      ex_irq_q <= ex_irq_n;
      ex_fiq_q <= ex_fiq_n;
      vec_q    <= vec_n;
      insvc_q  <= insvc_n;
    end
  end

  assign bus.EX_irq     = ex_irq_q;
  assign bus.EX_fiq     = ex_fiq_q;
  assign bus.INT_Vector = vec_q;
  assign bus.irq_id     = irq_id_q;
  assign bus.fiq_id     = fiq_id_q;
  assign bus.pending    = pend_q;
  assign bus.in_service = insvc_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Bench for int_arbiter: directed handshake scenarios plus random bursts; grants are
// checked by a monitor against per-class queues of expected source ids.
module tb_int_arbiter;
  localparam int          NSRC     = 8;
  localparam logic [31:0] IRQ_BASE = 32'h0000_0018;
  localparam logic [31:0] FIQ_BASE = 32'h0000_001C;

  logic            clk = 1'b0;
  logic            Rst = 1'b0;
  logic [NSRC-1:0] src_in = '0;

  int_arbiter_if #(.NSRC(NSRC)) bus ();

  int_arbiter #(.NSRC(NSRC), .IRQ_BASE(IRQ_BASE), .FIQ_BASE(FIQ_BASE)) dut (
    .clk(clk),
    .Rst(Rst),
    .src_in(src_in),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned irq_q[$];
  int unsigned fiq_q[$];
  logic prev_irq = 1'b0;
  logic prev_fiq = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every fresh request must match the head of its class queue.
  always @(negedge clk) begin
    if (!Rst) begin
      prev_irq = 1'b0;
      prev_fiq = 1'b0;
    end else begin
      if (bus.EX_irq && !prev_irq) begin
        if (irq_q.size() == 0) check("irq_grant_expected", 32'(irq_q.size() != 0), 32'd1);
        else begin
          int unsigned e;
          e = irq_q.pop_front();
          check("irq_grant_id", 32'(bus.irq_id), e);
          if (!bus.EX_fiq) check("irq_grant_vec", bus.INT_Vector, IRQ_BASE + e * 4);
        end
      end
      if (bus.EX_fiq && !prev_fiq) begin
        if (fiq_q.size() == 0) check("fiq_grant_expected", 32'(fiq_q.size() != 0), 32'd1);
        else begin
          int unsigned e;
          e = fiq_q.pop_front();
          check("fiq_grant_id", 32'(bus.fiq_id), e);
          check("fiq_grant_vec", bus.INT_Vector, FIQ_BASE + e * 4);
        end
      end
      prev_irq = bus.EX_irq;
      prev_fiq = bus.EX_fiq;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [NSRC-1:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = data;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic pulse_src(input logic [NSRC-1:0] s);
    src_in = s;
    ticks(2);
    src_in = '0;
  endtask

  task automatic irq_ack_pulse();
    bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
  endtask
  task automatic irq_eoi_pulse();
    bus.irq_eoi = 1'b1; tick(); bus.irq_eoi = 1'b0;
  endtask
  task automatic fiq_ack_pulse();
    bus.fiq_ack = 1'b1; tick(); bus.fiq_ack = 1'b0;
  endtask
  task automatic fiq_eoi_pulse();
    bus.fiq_eoi = 1'b1; tick(); bus.fiq_eoi = 1'b0;
  endtask

  task automatic wait_ex(input bit fiq, input string name);
    int unsigned n = 0;
    while (((fiq ? bus.EX_fiq : bus.EX_irq) !== 1'b1) && n < 60) begin
      tick();
      n++;
    end
    check(name, 32'(fiq ? bus.EX_fiq : bus.EX_irq), 32'd1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ex"}, 32'({bus.EX_fiq, bus.EX_irq}), 32'd0);
    check({name, "_vec"}, bus.INT_Vector, 32'd0);
    check({name, "_ids"}, 32'({bus.fiq_id, bus.irq_id}), 32'd0);
    check({name, "_pend"}, 32'(bus.pending), 32'd0);
    check({name, "_insvc"}, 32'(bus.in_service), 32'd0);
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.irq_ack = 1'b0; bus.fiq_ack = 1'b0; bus.irq_eoi = 1'b0; bus.fiq_eoi = 1'b0;
    ticks(3);
    check_all_zero("reset");
    Rst = 1'b1;
    tick();

    // Basic latency and handshake on source 0
    cfg_write(2'd0, 8'h01);
    cfg_write(2'd1, 8'h00);
    irq_q.push_back(0);
    src_in = 8'h01;
    ticks(2);
    src_in = '0;
    tick();
    check("lat_not_yet", 32'(bus.EX_irq), 32'd0);
    tick();
    check("lat_ex_irq", 32'(bus.EX_irq), 32'd1);
    check("lat_vec", bus.INT_Vector, 32'h18);
    check("lat_id", 32'(bus.irq_id), 32'd0);
    irq_ack_pulse();
    check("ack_ex_low", 32'(bus.EX_irq), 32'd0);
    check("ack_pend0", 32'(bus.pending[0]), 32'd0);
    check("ack_insvc", 32'(bus.in_service), 32'd1);
    irq_eoi_pulse();
    check("eoi_insvc", 32'(bus.in_service), 32'd0);

    // Simultaneous rises: lowest index first
    cfg_write(2'd0, 8'hFF);
    irq_q.push_back(2);
    irq_q.push_back(5);
    pulse_src(8'h24);
    wait_ex(1'b0, "prio_first");
    check("prio_vec2", bus.INT_Vector, 32'h20);
    irq_ack_pulse();
    irq_eoi_pulse();
    wait_ex(1'b0, "prio_second");
    check("prio_id5", 32'(bus.irq_id), 32'd5);
    check("prio_vec5", bus.INT_Vector, 32'h2C);
    irq_ack_pulse();
    irq_eoi_pulse();

    // FIQ preempts IRQ service; FIQ service blocks new IRQ requests
    cfg_write(2'd1, 8'h08);
    irq_q.push_back(1);
    pulse_src(8'h02);
    wait_ex(1'b0, "pre_irq1");
    irq_ack_pulse();
    fiq_q.push_back(3);
    pulse_src(8'h08);
    wait_ex(1'b1, "pre_fiq3");
    check("pre_fiq_vec", bus.INT_Vector, 32'h28);
    fiq_ack_pulse();
    irq_q.push_back(4);
    pulse_src(8'h10);
    ticks(3);
    irq_eoi_pulse();
    ticks(5);
    check("blocked_by_fiq", 32'(bus.EX_irq), 32'd0);
    check("blocked_pend4", 32'(bus.pending[4]), 32'd1);
    fiq_eoi_pulse();
    wait_ex(1'b0, "after_fiq_eoi");
    check("after_fiq_id4", 32'(bus.irq_id), 32'd4);
    irq_ack_pulse();
    irq_eoi_pulse();
    cfg_write(2'd1, 8'h00);

    // Masked edge stays pending until unmasked
    cfg_write(2'd0, 8'h00);
    pulse_src(8'h40);
    ticks(5);
    check("masked_pend6", 32'(bus.pending[6]), 32'd1);
    check("masked_no_ex", 32'(bus.EX_irq), 32'd0);
    irq_q.push_back(6);
    cfg_write(2'd0, 8'h40);
    tick();
    check("unmask_ex", 32'(bus.EX_irq), 32'd1);
    check("unmask_id6", 32'(bus.irq_id), 32'd6);
    irq_ack_pulse();
    irq_eoi_pulse();

    // Withdrawal during ASSERT, then rise coincident with ack
    cfg_write(2'd0, 8'hFF);
    irq_q.push_back(4);
    pulse_src(8'h10);
    wait_ex(1'b0, "wd_assert");
    check("wd_id4", 32'(bus.irq_id), 32'd4);
    cfg_write(2'd0, 8'h00);
    tick();
    check("wd_ex_low", 32'(bus.EX_irq), 32'd0);
    irq_q.push_back(4);
    cfg_write(2'd0, 8'hFF);
    wait_ex(1'b0, "wd_reassert");
    src_in = 8'h10;
    ticks(2);
    irq_ack_pulse();
    src_in = '0;
    check("coinc_pend4", 32'(bus.pending[4]), 32'd1);
    check("coinc_insvc", 32'(bus.in_service), 32'd1);
    irq_q.push_back(4);
    irq_eoi_pulse();
    wait_ex(1'b0, "coinc_regrant");
    irq_ack_pulse();
    irq_eoi_pulse();

    // Reset mid-handshake: IRQ in SERVICE, FIQ in ASSERT
    cfg_write(2'd1, 8'h08);
    irq_q.push_back(1);
    pulse_src(8'h02);
    wait_ex(1'b0, "rst_irq1");
    irq_ack_pulse();
    fiq_q.push_back(3);
    pulse_src(8'h08);
    wait_ex(1'b1, "rst_fiq3");
    #2;
    Rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    irq_q.delete();
    fiq_q.delete();
    tick();
    Rst = 1'b1;
    ticks(10);
    check_all_zero("post_rst");

    // Random bursts against a priority-order model
    for (int unsigned it = 0; it < 20; it++) begin
      logic [NSRC-1:0] set, fsel;
      int unsigned cnt, served, guard;
      set  = NSRC'($urandom_range(1, 255));
      fsel = NSRC'($urandom);
      cfg_write(2'd0, 8'hFF);
      cfg_write(2'd1, fsel);
      cnt = 0;
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (set[i]) begin
          cnt++;
          if (fsel[i]) fiq_q.push_back(i);
          else irq_q.push_back(i);
        end
      end
      pulse_src(set);
      served = 0;
      guard  = 0;
      while (served < cnt && guard < 400) begin
        if (bus.EX_fiq) begin
          ticks($urandom_range(0, 2));
          fiq_ack_pulse();
          fiq_eoi_pulse();
          served++;
        end else if (bus.EX_irq) begin
          ticks($urandom_range(0, 2));
          irq_ack_pulse();
          irq_eoi_pulse();
          served++;
        end else tick();
        guard++;
      end
      check("rand_served", served, cnt);
      ticks(2);
      check("rand_pend_clear", 32'(bus.pending), 32'd0);
    end

    ticks(3);
    check("irq_q_drained", irq_q.size(), 32'd0);
    check("fiq_q_drained", fiq_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
